// File: rtl/life_pkg.sv
// Shared types for the 16x16 life datapath and its reader-side streamer.
package life_pkg;
  localparam int GRID_ROWS = 16;
  localparam int GRID_COLS = 16;

  typedef logic [GRID_ROWS*GRID_COLS-1:0] grid_t;
  typedef logic [GRID_COLS-1:0] row_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DONE
  } stream_state_e;
endpackage

// File: rtl/grid_row_streamer.sv
// Snapshots the evolved grid on start and streams it one row per
// valid/ready handshake, row 0 first, then pulses frame_done.
module grid_row_streamer
  import life_pkg::*;
#(
  parameter int COLS = GRID_COLS,
  parameter int ROWS = GRID_ROWS,
  parameter int CNTW = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ROWS*COLS-1:0]   grid,
  input  logic                   start,
  output logic [COLS-1:0]        row_data,
  output logic [$clog2(ROWS)-1:0] row_idx,
  output logic                   row_valid,
  input  logic                   row_ready,
  output logic                   row_last,
  output logic                   busy,
  output logic                   frame_done,
  output logic [CNTW-1:0]        frame_count
);

  localparam int IW = $clog2(ROWS);
  localparam logic [IW-1:0] LAST_IDX = IW'(ROWS - 1);

  stream_state_e          state_q, state_d;
  logic [ROWS*COLS-1:0]   snap_q, snap_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic [COLS-1:0]        rows [ROWS];
  logic                   fire;

  assign fire = row_valid & row_ready;

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_d  = grid;
          idx_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (fire) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            cnt_d   = cnt_q + 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Row view of the snapshot, using the datapath's packing.
  for (genvar r = 0; r < ROWS; r++) begin : g_rows
    assign rows[r] = snap_q[r*COLS +: COLS];
  end

  assign row_data    = rows[idx_q];
  assign row_idx     = idx_q;
  assign row_valid   = (state_q == S_SEND);
  assign row_last    = row_valid & (idx_q == LAST_IDX);
  assign busy        = (state_q != S_IDLE);
  assign frame_done  = (state_q == S_DONE);
  assign frame_count = cnt_q;

endmodule
